seg_display_driver: RTL and testbench
=====================================

# seg_display_driver

Display back-end for the calculator: accepts the 20-bit result value and 3-bit operator code produced by the arithmetic core. It converts the value to 7 BCD digits with a sequential double-dabble engine and drives an 8-digit multiplexed 7-segment display:
- digits 0–6 show the number;
- digit 7 shows an operator glyph.

It sits between the processor output and the board's segment/digit pins.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays lit (1 kHz per digit at 50 MHz). Minimum 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- display_number  in  20  unsigned value to show (0..1048575).
- display_sign  in  3  operator code. 000 add, 001 minus, 010 multiply, 011 division, 100 reset, 101 equal, 110/111 none.
- seg  out  8  segment lines, active low. Bit order: [7]dp, [6]g, [5]f, [4]e, [3]d, [2]c, [1]b, [0]a.
- dig  out  8  digit enables, active low, one-hot. dig[0] is the rightmost digit.
- conv_done  out  1  one-cycle pulse when a new BCD result is committed.

## Operation
- **Conversion FSM**: states IDLE → SHIFT → COMMIT → IDLE, running continuously.
  - IDLE, 1 cycle: snapshot display_number into a 20-bit shift register and display_sign into sign_snap. Clear the 28-bit BCD work register.
  - SHIFT, exactly 20 cycles with a 5-bit counter 0..19. Each cycle:
    - add 3 to every BCD nibble ≥5;
    - then shift {bcd, bin} left by 1.
  - COMMIT, 1 cycle:
    - copy the work register to bcd_out[27:0] and sign_snap to sign_out;
    - pulse conv_done.
  - bcd_out and sign_out only change in COMMIT. The displayed number and sign are always from the same snapshot; a displayed value is never half-converted.
  - Input changes during SHIFT are ignored until the next IDLE.
- **Scanner**:
  - Cycle counter runs 0..SCAN_DIV-1. On wrap, digit index advances 0→1→…→7→0.
  - On each advance, register a new seg/dig pair in the same cycle, so the two never disagree.
  - dig = ~(8'b1 << index).
- **Digit codes**, for digits 0–6 (active low):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - BCD nibble >9 cannot occur; if it does, drive blank FF.
- **Sign glyphs**, for digit 7:
  - 000 'A' 88, 001 '-' BF, 010 'H' 89, 011 'd' A1, 100 'r' AF, 101 '=' B7, 110/111 blank FF.
- dp is always off (seg[7]=1).

## Timing
- **Reset values**:
  - seg=8'hFF, dig=8'hFF, conv_done=0;
  - bcd_out=0, sign_out=3'b111;
  - FSM in IDLE, scan counter 0, index 7, so the first advance selects digit 0.
- **Conversion latency**: 22 cycles from the IDLE snapshot to the conv_done pulse. One COMMIT occurs every 22 cycles, indefinitely.
- **Display latency**: a committed value appears on a given digit at that digit's next scan slot, i.e. within 8·SCAN_DIV cycles.
- **First lit digit**: appears SCAN_DIV cycles after reset deassertion. Before that, all digits are off.
- **Reset mid-conversion**: the partial result is discarded, and outputs return to reset values on the next edge.
- **Boundaries**:
  - display_number=0 shows a single '0' on digit 0 (with blanking enabled).
  - 1048575 uses all 7 number digits.
  - Values wrapped by subtraction are displayed as unsigned.

## Configuration
- LEADING_ZERO_BLANK_EN
  - **Defined**: digit k (1≤k≤6) shows blank FF when nibbles k..6 of bcd_out are all zero. Digit 0 is never blanked.
  - **Undefined**: all 7 number digits always show their value, including leading zeros. Example: 42 shows as 0000042.
  - Sign digit 7 is unaffected either way.

## Test plan
- **Reset**: assert rst for 3 cycles with SCAN_DIV=4.
  - Expect seg=FF and dig=FF during reset.
  - conv_done first pulses 22 cycles after release.
  - The first lit digit appears 4 cycles after release with dig=FE.
- **Maximum value**: display_number=1048575, sign=101.
  - After COMMIT, bcd_out=28'h1048575.
  - One full scan shows digits F9 C0 99 80 92 F8 92 on digits 6..0, and B7 on digit 7.
- **Blanking**: display_number=42, sign=000.
  - With LEADING_ZERO_BLANK_EN: digits 6..2 show FF, digit 1 shows 99, digit 0 shows A4, digit 7 shows 88.
  - Without the macro: digits 6..2 show C0.
- **Zero**: display_number=0, sign=111.
  - Digit 0 shows C0, digit 7 shows FF, and digits 1–6 follow the blanking rule.
- **Mid-conversion change**: change display_number from 123 to 456 on the 10th SHIFT cycle.
  - The next conv_done commits 123; the following one commits 456.
  - sign_out always matches the same snapshot.
- **Reset mid-SHIFT**: assert rst during cycle 5 of SHIFT.
  - All outputs return to reset values next edge; the next commit occurs 22 cycles after release.

Source files
------------

// File: rtl/seg_display_driver.sv
// seg_display_driver: converts a 20-bit result to 7 BCD digits and scans them, plus an operator glyph, onto an 8-digit 7-segment display.
// Latency: one commit every 22 cycles (snapshot, 20 shifts, commit); each digit is lit for SCAN_DIV cycles.
// Backpressure: none; inputs are sampled once per conversion, and input changes made while a conversion is running are ignored.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   display_number    unsigned value to show (0..1048575)
//   display_sign      operator code: 0 add, 1 minus, 2 mul, 3 div, 4 reset, 5 equal, 6/7 none
//   seg               active-low segments {dp,g,f,e,d,c,b,a}
//   dig               active-low one-hot digit enables, dig[0] rightmost
//   conv_done         one-cycle pulse when a new BCD result is committed
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on digits 1..6.

module seg_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] display_number,
  input  logic [2:0]  display_sign,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic        conv_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [19:0]    bin_q, bin_d;
  logic [27:0]    bcd_q, bcd_d;
  logic [2:0]     sign_snap_q, sign_snap_d;
  logic [27:0]    bcd_out_q, bcd_out_d;
  logic [2:0]     sign_out_q, sign_out_d;
  logic           conv_done_q, conv_done_d;
  logic [CW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     seg_q, seg_d;
  logic [7:0]     dig_q, dig_d;

  logic [27:0]    adj;
  logic [27:0]    nib_sh;
  logic [7:0]     blank;

  function automatic logic [7:0] digit_code(input logic [3:0] n);
    case (n)
      4'd0: digit_code = 8'hC0;
      4'd1: digit_code = 8'hF9;
      4'd2: digit_code = 8'hA4;
      4'd3: digit_code = 8'hB0;
      4'd4: digit_code = 8'h99;
      4'd5: digit_code = 8'h92;
      4'd6: digit_code = 8'h82;
      4'd7: digit_code = 8'hF8;
      4'd8: digit_code = 8'h80;
      4'd9: digit_code = 8'h90;
      default: digit_code = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] sign_code(input logic [2:0] s);
    case (s)
      3'b000: sign_code = 8'h88;
      3'b001: sign_code = 8'hBF;
      3'b010: sign_code = 8'h89;
      3'b011: sign_code = 8'hA1;
      3'b100: sign_code = 8'hAF;
      3'b101: sign_code = 8'hB7;
      default: sign_code = 8'hFF;
    endcase
  endfunction

  // Conversion FSM: double-dabble over {bcd, bin}, one bit per SHIFT cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    sign_snap_d = sign_snap_q;
    bcd_out_d   = bcd_out_q;
    sign_out_d  = sign_out_q;
    conv_done_d = 1'b0;
    adj         = bcd_q;
    case (state_q)
      S_IDLE: begin
        bin_d       = display_number;
        sign_snap_d = display_sign;
        bcd_d       = '0;
        cnt_d       = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        for (int i = 0; i < 7; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj[26:0], bin_q, 1'b0};
        if (cnt_q == 5'd19) state_d = S_COMMIT;
        else                cnt_d   = cnt_q + 5'd1;
      end
      S_COMMIT: begin
        bcd_out_d   = bcd_q;
        sign_out_d  = sign_snap_q;
        conv_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner: seg and dig are registered together on each digit advance.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CW'(1);
    idx_d      = idx_q;
    seg_d      = seg_q;
    dig_d      = dig_q;

    // blank[k]: nibbles k..6 of the committed value are all zero.
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    blank[6] = (bcd_out_q[27:24] == 4'd0);
    for (int k = 5; k >= 1; k--) begin
      blank[k] = blank[k+1] && (bcd_out_q[4*k +: 4] == 4'd0);
    end
`endif

    if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    nib_sh = bcd_out_q >> {idx_d, 2'b00};

    if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
      dig_d = ~(8'b1 << idx_d);
      if (idx_d == 3'd7)   seg_d = sign_code(sign_out_q);
      else if (blank[idx_d]) seg_d = 8'hFF;
      else                 seg_d = digit_code(nib_sh[3:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      sign_snap_q <= 3'b111;
      bcd_out_q   <= '0;
      sign_out_q  <= 3'b111;
      conv_done_q <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= 3'd7;
      seg_q       <= 8'hFF;
      dig_q       <= 8'hFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      sign_snap_q <= sign_snap_d;
      bcd_out_q   <= bcd_out_d;
      sign_out_q  <= sign_out_d;
      conv_done_q <= conv_done_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign seg       = seg_q;
  assign dig       = dig_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Testbench for seg_display_driver with SCAN_DIV=4. The reference model works on
// decimal arithmetic of the input value (divide/modulo by powers of ten).
module tb_seg_display_driver;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] display_number = '0;
  logic [2:0]  display_sign = '0;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic        conv_done;

  int n_assert = 0;
  int n_fail   = 0;

  seg_display_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst),
    .display_number(display_number), .display_sign(display_sign),
    .seg(seg), .dig(dig), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [27:0] model_bcd(input int v);
    logic [27:0] r = '0;
    for (int k = 0; k < 7; k++) r = r | (28'((v / pow10(k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [7:0] digit_glyph(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] sign_glyph(input int s);
    case (s)
      0: return 8'h88; 1: return 8'hBF; 2: return 8'h89;
      3: return 8'hA1; 4: return 8'hAF; 5: return 8'hB7;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int v, input int s, input int k);
    if (k == 7) return sign_glyph(s);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && v < pow10(k)) return 8'hFF;
`endif
    return digit_glyph((v / pow10(k)) % 10);
  endfunction

  // Waits for the next conv_done pulse (bounded); n = cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!conv_done && n < 60);
  endtask

  // Applies a value, lets it be committed, then checks one full scan.
  task automatic check_value(input int v, input int s, input string name);
    int n;
    logic [7:0] one;
    int idx;
    display_number = 20'(v);
    display_sign   = 3'(s);
    wait_done(n);
    wait_done(n);
    chk({name, "_commit_gap"}, n, 22);
    chk({name, "_bcd_out"}, dut.bcd_out_q, model_bcd(v));
    chk({name, "_sign_out"}, dut.sign_out_q, s);
    repeat (8 * SD) @(posedge clk);
    for (int c = 0; c < 8 * SD; c++) begin
      @(posedge clk); #1;
      idx = -1;
      for (int k = 0; k < 8; k++) begin
        one = 8'b1 << k;
        if (dig === ~one) idx = k;
      end
      chk({name, "_dig_onehot"}, (idx >= 0), 1);
      if (idx >= 0) chk($sformatf("%s_seg_d%0d", name, idx), seg, model_seg(v, s, idx));
    end
  endtask

  initial begin
    int n;
    int first_lit;
    int first_done;

    // Reset held for 3 cycles.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_seg", seg, 8'hFF);
      chk("rst_dig", dig, 8'hFF);
      chk("rst_conv_done", conv_done, 0);
    end
    rst = 1'b0;
    first_lit = -1;
    first_done = -1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (first_lit < 0 && dig !== 8'hFF) begin
        first_lit = t;
        chk("first_lit_dig", dig, 8'hFE);
        chk("first_lit_seg", seg, 8'hC0);
      end
      if (first_done < 0 && conv_done === 1'b1) begin
        first_done = t;
        chk("first_bcd_out", dut.bcd_out_q, 28'h0);
        chk("first_sign_out", dut.sign_out_q, 0);
      end
    end
    chk("first_lit_cycle", first_lit, SD);
    chk("first_done_cycle", first_done, 22);

    // Directed boundary values.
    check_value(1048575, 5, "max");
    check_value(42, 0, "blank42");
    check_value(0, 7, "zero");

    // Random values and signs.
    for (int r = 0; r < 6; r++) begin
      check_value(int'($urandom_range(0, 1048575)), int'($urandom_range(0, 7)), $sformatf("rnd%0d", r));
    end

    // Input change on the 10th SHIFT cycle is ignored until the next snapshot.
    wait_done(n);
    display_number = 20'd123;
    display_sign   = 3'b001;
    repeat (10) @(posedge clk);
    #1;
    display_number = 20'd456;
    display_sign   = 3'b010;
    wait_done(n);
    chk("mid_gap1", n, 12);
    chk("mid_bcd1", dut.bcd_out_q, 28'h123);
    chk("mid_sign1", dut.sign_out_q, 1);
    wait_done(n);
    chk("mid_gap2", n, 22);
    chk("mid_bcd2", dut.bcd_out_q, 28'h456);
    chk("mid_sign2", dut.sign_out_q, 2);

    // Reset during SHIFT.
    wait_done(n);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_dig", dig, 8'hFF);
    chk("midrst_conv_done", conv_done, 0);
    chk("midrst_bcd_out", dut.bcd_out_q, 28'h0);
    chk("midrst_sign_out", dut.sign_out_q, 7);
    rst = 1'b0;
    wait_done(n);
    chk("midrst_commit_gap", n, 22);
    chk("midrst_bcd_after", dut.bcd_out_q, model_bcd(456));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
